// File: rtl/pht_update_queue_pkg.sv
// Shared fetch-unit types for PHT update buffering: entry layout and the
// 2-bit saturating counter update.
package pht_update_queue_pkg;

    localparam int unsigned PHT_INDEX_WIDTH = 10;

    typedef logic [1:0] PHT_CounterPath;

    typedef struct packed {
        logic                       valid;
        logic [PHT_INDEX_WIDTH-1:0] index;
        PHT_CounterPath             counter;
    } PHT_UpdateEntry;

    function automatic PHT_CounterPath PHT_NextCount(input PHT_CounterPath counter,
                                                     input logic           taken);
        PHT_CounterPath next;
        if (taken) begin
            next = (counter == 2'd3) ? 2'd3 : counter + 2'd1;
        end else begin
            next = (counter == 2'd0) ? 2'd0 : counter - 2'd1;
        end
        return next;
    endfunction

endpackage

// File: rtl/pht_update_forward.sv
// Youngest-match search over the live queue entries, so a push can build on a
// counter value that has not reached the PHT yet.
module pht_update_forward
    import pht_update_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned OCC_W = PTR_W + 1
) (
    input  PHT_UpdateEntry             entries [DEPTH],
    input  logic [PTR_W-1:0]           head,
    input  logic [PTR_W-1:0]           tail,
    input  logic [OCC_W-1:0]           occupancy,
    input  logic [PHT_INDEX_WIDTH-1:0] push_index,
    output logic                       hit,
    output PHT_CounterPath             counter
);

    logic             full;
    logic [PTR_W-1:0] span;
    logic [PTR_W-1:0] slot;

    // Walk oldest to youngest; the last match (closest to tail) wins.
    always_comb begin
        hit     = 1'b0;
        counter = '0;
        full    = (occupancy == OCC_W'(DEPTH));
        span    = tail - head;
        slot    = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if ((full || (PTR_W'(k) < span)) && entries[slot].valid &&
                (entries[slot].index == push_index)) begin
                hit     = 1'b1;
                counter = entries[slot].counter;
            end
        end
    end

endmodule

// File: rtl/pht_update_queue.sv
// Circular buffer of resolved branch outcomes that drains final counter values
// into the PHT write port whenever the array is not reserved for prediction.
module pht_update_queue
    import pht_update_queue_pkg::*;
#(
    parameter  int unsigned DEPTH       = 4,
    parameter  int unsigned INDEX_WIDTH = PHT_INDEX_WIDTH,
    localparam int unsigned PTR_W       = $clog2(DEPTH),
    localparam int unsigned OCC_W       = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    input  logic [INDEX_WIDTH-1:0] push_index,
    input  logic                   push_taken,
    input  logic [1:0]             push_count,
    output logic                   push_ready,
    output logic                   push_dropped,
    input  logic                   pht_busy,
    output logic                   pht_we,
    output logic [INDEX_WIDTH-1:0] pht_wa,
    output logic [1:0]             pht_wv,
    output logic [OCC_W-1:0]       occupancy,
    output logic                   empty
);

    PHT_UpdateEntry   entries_q [DEPTH];
    PHT_UpdateEntry   entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic                       push_acc;
    logic                       fwd_hit;
    PHT_CounterPath             fwd_cnt;
    PHT_CounterPath             base_cnt;
    PHT_CounterPath             new_cnt;
    logic [PHT_INDEX_WIDTH-1:0] push_index_ext;

    assign push_index_ext = PHT_INDEX_WIDTH'(push_index);

    pht_update_forward #(
        .DEPTH (DEPTH)
    ) u_forward (
        .entries    (entries_q),
        .head       (head_q),
        .tail       (tail_q),
        .occupancy  (occ_q),
        .push_index (push_index_ext),
        .hit        (fwd_hit),
        .counter    (fwd_cnt)
    );

    // Handshake and PHT port: purely from registered state plus this cycle's inputs.
    always_comb begin
        occupancy    = occ_q;
        empty        = (occ_q == '0);
        push_ready   = (occ_q != OCC_W'(DEPTH));
        push_dropped = push_valid && !push_ready;
        push_acc     = push_valid && push_ready;
        pht_we       = !empty && !pht_busy && !rst;
        pht_wa       = INDEX_WIDTH'(entries_q[head_q].index);
        pht_wv       = entries_q[head_q].counter;
        base_cnt     = fwd_hit ? fwd_cnt : PHT_CounterPath'(push_count);
        new_cnt      = PHT_NextCount(base_cnt, push_taken);
    end

    // Queue next state: pop at head on a write, append at tail on an accepted push.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        if (pht_we) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end
        if (push_acc) begin
            entries_d[tail_q].valid   = 1'b1;
            entries_d[tail_q].index   = push_index_ext;
            entries_d[tail_q].counter = new_cnt;
            tail_d                    = tail_q + PTR_W'(1);
        end
        case ({push_acc, pht_we})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
        end
    end

endmodule

// File: tb/tb_pht_update_queue.sv
// Scoreboard bench for pht_update_queue: stimulus queues expected PHT writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_pht_update_queue;

    logic       clk;
    logic       rst;
    logic       push_valid;
    logic [9:0] push_index;
    logic       push_taken;
    logic [1:0] push_count;
    logic       push_ready;
    logic       push_dropped;
    logic       pht_busy;
    logic       pht_we;
    logic [9:0] pht_wa;
    logic [1:0] pht_wv;
    logic [2:0] occupancy;
    logic       empty;

    typedef struct {
        logic [9:0] idx;
        logic [1:0] val;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    pht_update_queue #(
        .DEPTH       (4),
        .INDEX_WIDTH (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_index   (push_index),
        .push_taken   (push_taken),
        .push_count   (push_count),
        .push_ready   (push_ready),
        .push_dropped (push_dropped),
        .pht_busy     (pht_busy),
        .pht_we       (pht_we),
        .pht_wa       (pht_wa),
        .pht_wv       (pht_wv),
        .occupancy    (occupancy),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] idx, input logic tk, input logic [1:0] cnt,
                        input logic [1:0] expv, input bit expect_acc);
        push_valid = 1'b1;
        push_index = idx;
        push_taken = tk;
        push_count = cnt;
        if (expect_acc) sb.push_back('{idx: idx, val: expv});
        step();
        push_valid = 1'b0;
    endtask

    // Monitor: every PHT write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && pht_we) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: got wa=%0h wv=%0d expected no write", pht_wa, pht_wv);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pht_wa !== e.idx || pht_wv !== e.val) begin
                    mismatched++;
                    $display("FAIL pht_write: got wa=%0h wv=%0d expected wa=%0h wv=%0d",
                             pht_wa, pht_wv, e.idx, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_index = '0;
        push_taken = 1'b0;
        push_count = '0;
        pht_busy   = 1'b0;
        step();
        step();
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_push_ready", 32'(push_ready), 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_pht_we", 32'(pht_we), 0);
        chk("rst_pht_wa", 32'(pht_wa), 0);
        chk("rst_pht_wv", 32'(pht_wv), 0);
        chk("rst_dropped", 32'(push_dropped), 0);
        rst = 1'b0;
        step();

        // Single push: write visible the cycle after acceptance.
        push(10'h005, 1'b1, 2'd1, 2'd2, 1'b1);
        chk("single_we", 32'(pht_we), 1);
        chk("single_wa", 32'(pht_wa), 32'h005);
        chk("single_wv", 32'(pht_wv), 2);
        step();
        chk("single_empty", 32'(empty), 1);

        // Saturation at both ends.
        push(10'h021, 1'b1, 2'd3, 2'd3, 1'b1);
        push(10'h022, 1'b0, 2'd0, 2'd0, 1'b1);
        repeat (3) step();
        chk("sat_empty", 32'(empty), 1);

        // Forwarding chain on one index while the PHT is busy.
        pht_busy = 1'b1;
        push(10'h010, 1'b1, 2'd0, 2'd1, 1'b1);
        push(10'h010, 1'b1, 2'd0, 2'd2, 1'b1);
        push(10'h010, 1'b1, 2'd0, 2'd3, 1'b1);
        chk("fwd_occupancy", 32'(occupancy), 3);
        chk("fwd_no_write", 32'(pht_we), 0);
        pht_busy = 1'b0;
        repeat (4) step();
        chk("fwd_empty", 32'(empty), 1);

        // Fill, drop, and drop-while-popping.
        pht_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(10'h030 + 10'(i), 1'b0, 2'd2, 2'd1, 1'b1);
        push_valid = 1'b1;
        push_index = 10'h034;
        push_taken = 1'b1;
        push_count = 2'd0;
        #1;
        chk("full_dropped", 32'(push_dropped), 1);
        chk("full_ready", 32'(push_ready), 0);
        chk("full_occupancy", 32'(occupancy), 4);
        step();
        pht_busy = 1'b0;
        #1;
        chk("full_pop_dropped", 32'(push_dropped), 1);
        chk("full_pop_we", 32'(pht_we), 1);
        step();
        push_valid = 1'b0;
        chk("full_after_pop_occ", 32'(occupancy), 3);
        repeat (5) step();
        chk("full_drained", 32'(empty), 1);

        // Wrap-around with the PHT busy every other cycle.
        pht_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int budget = 20;
            while (!push_ready && budget > 0) begin
                pht_busy = ~pht_busy;
                step();
                budget--;
            end
            if (budget == 0) chk("wrap_ready_timeout", 0, 1);
            pht_busy = ~pht_busy;
            push(10'h040 + 10'(i), 1'(i % 2), 2'd1, (i % 2 == 1) ? 2'd2 : 2'd0, 1'b1);
            chk("wrap_occ_bound", 32'(occupancy <= 3'd4), 1);
        end
        pht_busy = 1'b0;
        repeat (6) step();
        chk("wrap_drained", 32'(sb.size()), 0);

        // Reset mid-operation discards queued updates and forwarding state.
        pht_busy = 1'b1;
        push(10'h050, 1'b1, 2'd1, 2'd2, 1'b0);
        push(10'h051, 1'b1, 2'd1, 2'd2, 1'b0);
        push(10'h052, 1'b1, 2'd1, 2'd2, 1'b0);
        chk("midrst_queued", 32'(occupancy), 3);
        rst = 1'b1;
        #1;
        chk("midrst_we_in_rst", 32'(pht_we), 0);
        chk("midrst_occ_in_rst", 32'(occupancy), 0);
        #1;
        rst = 1'b0;
        step();
        pht_busy = 1'b0;
        #1;
        chk("midrst_we", 32'(pht_we), 0);
        chk("midrst_occ", 32'(occupancy), 0);
        chk("midrst_ready", 32'(push_ready), 1);
        push(10'h050, 1'b1, 2'd0, 2'd1, 1'b1);
        repeat (3) step();
        chk("final_scoreboard_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
